// File: rtl/qspi_sram_responder.sv
// qspi_sram_responder
// Device end of a quad-SPI bus, backed by an internal byte array. Decodes
// quad read (0xEB: cmd, 24-bit addr, dummy, data) and quad write (0x38: cmd,
// 24-bit addr, data) transactions. The bus pins are oversampled with the
// system clock, so the block lives entirely in the `clock` domain.
//
// Parameters:
//   MEM_ADDR_WIDTH - array holds 2^MEM_ADDR_WIDTH bytes; address wraps within a burst
//   DUMMY_CYCLES   - qspi_clk rises between last address nibble and first read nibble
// Ports:
//   clock, reset            - system clock, asynchronous active-low reset
//   qspi_clk, qspi_select   - bus clock and active-low chip select (sampled as data)
//   qspi_data_in            - nibble from initiator, captured on qspi_clk rise
//   qspi_data_out/_oe       - nibble to initiator, updated on qspi_clk fall
//   load_en/addr/data       - backdoor byte write; a bus write commit wins a collision
//   busy                    - a transaction is in progress
module qspi_sram_responder #(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned DUMMY_CYCLES   = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      qspi_clk,
  input  logic                      qspi_select,
  input  logic [3:0]                qspi_data_in,
  output logic [3:0]                qspi_data_out,
  output logic                      qspi_data_oe,
  input  logic                      load_en,
  input  logic [MEM_ADDR_WIDTH-1:0] load_addr,
  input  logic [7:0]                load_data,
  output logic                      busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_R, S_ADDR_W, S_DUMMY, S_READ, S_WRITE, S_IGNORE
  } state_t;

  localparam int unsigned DEPTH = 1 << MEM_ADDR_WIDTH;
  // Shift register keeps just enough nibbles to form the command byte or the
  // used address bits; higher address nibbles simply fall off the top.
  localparam int unsigned SH = (MEM_ADDR_WIDTH > 8) ? MEM_ADDR_WIDTH - 4 : 4;
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  // Input synchronizers and edge detection
  logic [1:0] clk_sync, sel_sync;
  logic [3:0] din_s1, din_s2;
  logic       clk_prev;
  logic       rise, fall, sel_high;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync <= '0;
      sel_sync <= '0;
      din_s1   <= '0;
      din_s2   <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], qspi_clk};
      sel_sync <= {sel_sync[0], qspi_select};
      din_s1   <= qspi_data_in;
      din_s2   <= din_s1;
      clk_prev <= clk_sync[1];
    end
  end

  assign rise     = clk_sync[1] & ~clk_prev;
  assign fall     = ~clk_sync[1] & clk_prev;
  assign sel_high = sel_sync[1];

  // State and datapath registers
  state_t                    state, state_next;
  logic                      armed;
  logic [7:0]                cnt;
  logic [SH-1:0]             shreg;
  logic [MEM_ADDR_WIDTH-1:0] addr, addr_next;
  logic                      phase;
  logic [3:0]                hi_nib;
  logic [7:0]                cmd_byte, rd_byte;
  logic                      wr_en;
  logic [7:0]                mem [DEPTH];

  assign cmd_byte  = {shreg[3:0], din_s2};
  assign addr_next = MEM_ADDR_WIDTH'({shreg, din_s2});
  assign wr_en     = (state == S_WRITE) && rise && phase && !sel_high;
  assign busy      = (state != S_IDLE);

  // armed is cleared by reset and only set once select is seen high, so a
  // reset with select held low cannot start decoding mid-transaction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      if (sel_high) armed <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (!sel_high && armed) state_next = S_CMD;
      S_CMD:    if (rise && cnt == 8'd1) begin
                  if (cmd_byte == 8'hEB)      state_next = S_ADDR_R;
                  else if (cmd_byte == 8'h38) state_next = S_ADDR_W;
                  else                        state_next = S_IGNORE;
                end
      S_ADDR_R: if (rise && cnt == 8'd5) state_next = (DUMMY_CYCLES == 0) ? S_READ : S_DUMMY;
      S_ADDR_W: if (rise && cnt == 8'd5) state_next = S_WRITE;
      S_DUMMY:  if (rise && cnt == DUMMY_LAST) state_next = S_READ;
      default:  ;
    endcase
    if (sel_high) state_next = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      shreg         <= '0;
      addr          <= '0;
      phase         <= 1'b0;
      hi_nib        <= '0;
      qspi_data_out <= '0;
      qspi_data_oe  <= 1'b0;
    end else if (sel_high) begin
      cnt           <= '0;
      phase         <= 1'b0;
      qspi_data_out <= '0;
      qspi_data_oe  <= 1'b0;
    end else begin
      case (state)
        S_CMD, S_ADDR_R, S_ADDR_W, S_DUMMY: if (rise) begin
          shreg <= SH'({shreg, din_s2});
          cnt   <= (state_next != state) ? '0 : cnt + 8'd1;
          if ((state == S_ADDR_R || state == S_ADDR_W) && state_next != state)
            addr <= addr_next;
        end
        S_READ: if (fall) begin
          qspi_data_oe  <= 1'b1;
          qspi_data_out <= phase ? rd_byte[3:0] : rd_byte[7:4];
          phase         <= ~phase;
          if (phase) addr <= addr + MEM_ADDR_WIDTH'(1);
        end
        S_WRITE: if (rise) begin
          if (!phase) begin
            hi_nib <= din_s2;
            phase  <= 1'b1;
          end else begin
            phase <= 1'b0;
            addr  <= addr + MEM_ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Array: contents are not reset. rd_byte tracks addr one cycle behind, which
  // is long settled before the next qspi_clk fall.
  always_ff @(posedge clock) begin
    if (wr_en)        mem[addr]      <= {hi_nib, din_s2};
    else if (load_en) mem[load_addr] <= load_data;
    rd_byte <= mem[addr];
  end

endmodule

// File: tb/tb_qspi_sram_responder.sv
module tb_qspi_sram_responder;

  localparam int HALF  = 50;
  localparam int DUMMY = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       qspi_clk = 1'b0;
  logic       qspi_select = 1'b1;
  logic [3:0] qspi_data_in = '0;
  logic [3:0] qspi_data_out;
  logic       qspi_data_oe;
  logic       load_en = 1'b0;
  logic [9:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [3:0] rd_nib [16];
  logic       oe_early;
  logic       oe_drop;
  logic [7:0] wr_buf [4];

  qspi_sram_responder #(.MEM_ADDR_WIDTH(10), .DUMMY_CYCLES(DUMMY)) dut (
    .clock(clock), .reset(reset), .qspi_clk(qspi_clk), .qspi_select(qspi_select),
    .qspi_data_in(qspi_data_in), .qspi_data_out(qspi_data_out), .qspi_data_oe(qspi_data_oe),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- initiator-side bus primitives (no checking inside) ----
  task automatic nib(input logic [3:0] n);
    qspi_data_in = n;
    #HALF;
    if (qspi_data_oe) oe_early = 1'b1;
    qspi_clk = 1'b1;
    #HALF;
    qspi_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    nib(b[7:4]);
    nib(b[3:0]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4]);
  endtask

  task automatic start_read(input logic [23:0] a);
    qspi_select = 1'b0;
    #HALF;
    oe_early = 1'b0;
    send_byte(8'hEB);
    send_addr(a);
    repeat (DUMMY) nib(4'h0);
  endtask

  task automatic read_nibbles(input int n);
    oe_drop = 1'b0;
    for (int i = 0; i < n; i++) begin
      #HALF;
      if (!qspi_data_oe) oe_drop = 1'b1;
      rd_nib[i] = qspi_data_out;
      qspi_clk = 1'b1;
      #HALF;
      qspi_clk = 1'b0;
    end
  endtask

  task automatic deselect();
    qspi_select = 1'b1;
    #100;
  endtask

  task automatic write_burst(input logic [23:0] a, input int n);
    qspi_select = 1'b0;
    #HALF;
    send_byte(8'h38);
    send_addr(a);
    for (int i = 0; i < n; i++) send_byte(wr_buf[i]);
    deselect();
  endtask

  task automatic load_byte(input logic [9:0] a, input logic [7:0] d);
    @(negedge clock);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    #30;
    checks++; if (qspi_data_out !== 4'h0) begin errors++; $display("FAIL reset_out got %h exp 0", qspi_data_out); end
    checks++; if (qspi_data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", qspi_data_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1'b1;
    #50;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_preload_read();
    logic [3:0] exp [8];
    exp = '{4'hA, 4'h5, 4'h3, 4'hC, 4'h0, 4'hF, 4'hF, 4'h0};
    load_byte(10'h000, 8'hA5);
    load_byte(10'h001, 8'h3C);
    load_byte(10'h002, 8'h0F);
    load_byte(10'h003, 8'hF0);
    start_read(24'h000000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy got %b exp 1", busy); end
    checks++; if (oe_early !== 1'b0) begin errors++; $display("FAIL read_oe_before_data got %b exp 0", oe_early); end
    read_nibbles(8);
    checks++; if (oe_drop !== 1'b0) begin errors++; $display("FAIL read_oe_in_data got_low %b exp 0", oe_drop); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_nib[i] !== exp[i]) begin errors++; $display("FAIL read_nib%0d got %h exp %h", i, rd_nib[i], exp[i]); end
    end
    deselect();
    checks++; if (qspi_data_oe !== 1'b0) begin errors++; $display("FAIL read_oe_after got %b exp 0", qspi_data_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_write_readback();
    logic [7:0] exp [4];
    exp = '{8'h12, 8'h34, 8'h56, 8'h99};
    load_byte(10'h013, 8'h99);
    wr_buf = '{8'h12, 8'h34, 8'h56, 8'h00};
    write_burst(24'h000010, 3);
    start_read(24'h000010);
    read_nibbles(8);
    deselect();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd_nib[2*i], rd_nib[2*i+1]} !== exp[i]) begin
        errors++; $display("FAIL wr_rb_byte%0d got %h exp %h", i, {rd_nib[2*i], rd_nib[2*i+1]}, exp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    load_byte(10'h3FF, 8'h5A);
    start_read(24'h0003FF);
    read_nibbles(4);
    deselect();
    checks++; if ({rd_nib[0], rd_nib[1]} !== 8'h5A) begin errors++; $display("FAIL wrap_3ff got %h exp 5a", {rd_nib[0], rd_nib[1]}); end
    checks++; if ({rd_nib[2], rd_nib[3]} !== 8'hA5) begin errors++; $display("FAIL wrap_000 got %h exp a5", {rd_nib[2], rd_nib[3]}); end
    start_read(24'hFFFC00);
    read_nibbles(2);
    deselect();
    checks++; if ({rd_nib[0], rd_nib[1]} !== 8'hA5) begin errors++; $display("FAIL alias_fffc00 got %h exp a5", {rd_nib[0], rd_nib[1]}); end
  endtask

  task automatic test_unknown_cmd();
    logic [7:0] exp [4];
    exp = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
    qspi_select = 1'b0;
    #HALF;
    oe_early = 1'b0;
    send_byte(8'h9F);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL unk_busy got %b exp 1", busy); end
    for (int i = 0; i < 16; i++) nib(4'(i));
    checks++; if (oe_early !== 1'b0) begin errors++; $display("FAIL unk_oe got %b exp 0", oe_early); end
    deselect();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL unk_busy_after got %b exp 0", busy); end
    start_read(24'h000000);
    read_nibbles(8);
    deselect();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd_nib[2*i], rd_nib[2*i+1]} !== exp[i]) begin
        errors++; $display("FAIL unk_array%0d got %h exp %h", i, {rd_nib[2*i], rd_nib[2*i+1]}, exp[i]);
      end
    end
  endtask

  task automatic test_abort();
    load_byte(10'h020, 8'h11);
    qspi_select = 1'b0;
    #HALF;
    send_byte(8'h38);
    send_addr(24'h000020);
    nib(4'h7);
    deselect();
    start_read(24'h000020);
    read_nibbles(2);
    deselect();
    checks++; if ({rd_nib[0], rd_nib[1]} !== 8'h11) begin errors++; $display("FAIL abort_wr got %h exp 11", {rd_nib[0], rd_nib[1]}); end
    start_read(24'h000000);
    read_nibbles(3);
    qspi_select = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (qspi_data_oe !== 1'b0) begin errors++; $display("FAIL abort_rd_oe got %b exp 0", qspi_data_oe); end
    checks++; if (qspi_data_out !== 4'h0) begin errors++; $display("FAIL abort_rd_out got %h exp 0", qspi_data_out); end
    @(negedge clock);
    #100;
    start_read(24'h000000);
    read_nibbles(4);
    deselect();
    checks++; if ({rd_nib[0], rd_nib[1], rd_nib[2], rd_nib[3]} !== 16'hA53C) begin
      errors++; $display("FAIL abort_reread got %h exp a53c", {rd_nib[0], rd_nib[1], rd_nib[2], rd_nib[3]});
    end
  endtask

  task automatic test_reset_mid_read();
    start_read(24'h000000);
    read_nibbles(2);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (qspi_data_out !== 4'h0) begin errors++; $display("FAIL rst_mid_out got %h exp 0", qspi_data_out); end
    checks++; if (qspi_data_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_oe got %b exp 0", qspi_data_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    #19;
    reset = 1'b1;
    #50;
    oe_early = 1'b0;
    send_byte(8'hEB);
    send_addr(24'h000000);
    repeat (DUMMY) nib(4'h0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_rearm_busy got %b exp 0", busy); end
    read_nibbles(2);
    checks++; if (oe_drop !== 1'b1) begin errors++; $display("FAIL rst_rearm_oe got_low %b exp 1", oe_drop); end
    deselect();
    start_read(24'h000000);
    read_nibbles(2);
    deselect();
    checks++; if ({rd_nib[0], rd_nib[1]} !== 8'hA5) begin errors++; $display("FAIL rst_reread got %h exp a5", {rd_nib[0], rd_nib[1]}); end
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_write_readback();
    test_wrap();
    test_unknown_cmd();
    test_abort();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
